// File: rtl/bash_hash_params_pkg.sv
// Bash-f constants, the bash_s column step and the round-constant LFSR step.
// Shared by the round datapath and its sequencer.
package bash_hash_params_pkg;

    localparam int SLEN = 64;

    localparam logic [SLEN-1:0] BASH_C1     = 64'h3BF5080AC8BA94B1;
    localparam logic [SLEN-1:0] BASH_C_POLY = 64'hDC2BE1997FE0D8AE;

    // (m1, n1, m2, n2) per column; each column is the previous one times 7 mod 64
    localparam logic [5:0] BASH_S_PRM [8][4] = '{
        '{6'd8,  6'd53, 6'd14, 6'd1 },
        '{6'd56, 6'd51, 6'd34, 6'd7 },
        '{6'd8,  6'd37, 6'd46, 6'd49},
        '{6'd56, 6'd3,  6'd2,  6'd23},
        '{6'd8,  6'd21, 6'd14, 6'd33},
        '{6'd56, 6'd19, 6'd34, 6'd39},
        '{6'd8,  6'd5,  6'd46, 6'd17},
        '{6'd56, 6'd35, 6'd2,  6'd55}
    };

    localparam logic [4:0] BASH_PI [24] = '{
        5'd15, 5'd10, 5'd9,  5'd12, 5'd11, 5'd14, 5'd13, 5'd8,
        5'd17, 5'd16, 5'd19, 5'd18, 5'd21, 5'd20, 5'd23, 5'd22,
        5'd6,  5'd3,  5'd0,  5'd5,  5'd2,  5'd7,  5'd4,  5'd1
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bash_f_state_e;

    function automatic logic [SLEN-1:0] rotl(input logic [SLEN-1:0] x, input logic [5:0] n);
        logic [2*SLEN-1:0] d;
        d = {x, x} << n;
        return d[2*SLEN-1:SLEN];
    endfunction

    function automatic logic [SLEN-1:0] c_step(input logic [SLEN-1:0] c);
        return (c >> 1) ^ (c[0] ? BASH_C_POLY : '0);
    endfunction

    // Returns {w0, w1, w2}
    function automatic logic [3*SLEN-1:0] bash_s(
        input logic [SLEN-1:0] w0,
        input logic [SLEN-1:0] w1,
        input logic [SLEN-1:0] w2,
        input logic [5:0]      m1,
        input logic [5:0]      n1,
        input logic [5:0]      m2,
        input logic [5:0]      n2
    );
        logic [SLEN-1:0] t0, t1, t2, u0, u1, u2;
        t2 = rotl(w0, m1);
        u0 = w0 ^ w1 ^ w2;
        t1 = w1 ^ rotl(u0, n1);
        u1 = t1 ^ t2;
        u2 = w2 ^ rotl(w2, m2) ^ (t1 << n2);
        t1 = u0 | u2;
        t2 = u0 & u1;
        t0 = ~u2 | u1;
        return {u0 ^ t0, u1 ^ t1, u2 ^ t2};
    endfunction

endpackage

// File: rtl/bash_f_round.sv
// One Bash-f round: eight bash_s columns, word permutation P, constant into S[23].
// Latency: purely combinational. Backpressure: none, no state.
module bash_f_round
    import bash_hash_params_pkg::*;
(
    input  logic [24*SLEN-1:0] s_i,
    input  logic [SLEN-1:0]    c_i,
    output logic [24*SLEN-1:0] s_o
);

    logic [SLEN-1:0] w [24];

    for (genvar i = 0; i < 8; i++) begin : g_col
        logic [3*SLEN-1:0] col;
        assign col = bash_s(s_i[SLEN*i +: SLEN], s_i[SLEN*(i+8) +: SLEN], s_i[SLEN*(i+16) +: SLEN],
                            BASH_S_PRM[i][0], BASH_S_PRM[i][1], BASH_S_PRM[i][2], BASH_S_PRM[i][3]);
        assign w[i]    = col[3*SLEN-1 -: SLEN];
        assign w[i+8]  = col[2*SLEN-1 -: SLEN];
        assign w[i+16] = col[SLEN-1:0];
    end

    for (genvar j = 0; j < 24; j++) begin : g_perm
        if (j == 23) begin : g_const
            assign s_o[SLEN*j +: SLEN] = w[BASH_PI[j]] ^ c_i;
        end else begin : g_pass
            assign s_o[SLEN*j +: SLEN] = w[BASH_PI[j]];
        end
    end

endmodule

// File: rtl/bash_f_ctrl.sv
// Bash-f round sequencer: loads a state, iterates ROUNDS rounds, returns the result.
// Latency: ROUNDS+1 cycles accept to out_valid (ROUNDS/2+1 with BASH_F_UNROLL2_EN).
// Backpressure: result and out_valid_o hold until out_ready_i; in_ready_o only in IDLE.
module bash_f_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int ROUNDS = 24
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [24*SLEN-1:0] state_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [24*SLEN-1:0] state_o,
    output logic               busy_o,
    output logic [4:0]         round_o
);

`ifdef BASH_F_UNROLL2_EN
    localparam logic [4:0] STEP = 5'd2;
`else
    localparam logic [4:0] STEP = 5'd1;
`endif
    // Counter value of the final RUN cycle, after the last round has been registered
    localparam logic [4:0] LAST = 5'(ROUNDS);

    bash_f_state_e      state_q, state_d;
    logic [24*SLEN-1:0] s_q, s1, round_s;
    logic [SLEN-1:0]    c_q, c_adv;
    logic [4:0]         round_q;
    logic               load, step, drain;

    bash_f_round u_round0 (.s_i(s_q), .c_i(c_q), .s_o(s1));

`ifdef BASH_F_UNROLL2_EN
    logic [SLEN-1:0]    c_mid;
    logic [24*SLEN-1:0] s2;
    assign c_mid = c_step(c_q);
    bash_f_round u_round1 (.s_i(s1), .c_i(c_mid), .s_o(s2));
    assign round_s = s2;
    assign c_adv   = c_step(c_mid);
`else
    assign round_s = s1;
    assign c_adv   = c_step(c_q);
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        drain       = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (round_q == LAST) begin
                    drain   = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s_q     <= '0;
            c_q     <= BASH_C1;
            round_q <= '0;
        end else if (load) begin
            s_q     <= state_i;
            c_q     <= BASH_C1;
            round_q <= '0;
        end else if (step) begin
            s_q     <= round_s;
            c_q     <= c_adv;
            round_q <= round_q + STEP;
        end else if (drain) begin
            round_q <= '0;
        end
    end

    assign state_o = s_q;
    assign round_o = drain ? 5'd0 : round_q;

endmodule

// File: tb/tb_bash_f_ctrl.sv
// Directed bench for bash_f_ctrl against a behavioural Bash-f reference.
module tb_bash_f_ctrl;

    localparam int ROUNDS = 24;
`ifdef BASH_F_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = ROUNDS / STEP + 1;

    localparam logic [63:0] C1   = 64'h3BF5080AC8BA94B1;
    localparam logic [63:0] C2   = 64'hC1D1659C1BBD92F6;
    localparam logic [63:0] POLY = 64'hDC2BE1997FE0D8AE;

    localparam logic [63:0] STD_W [24] = '{
        64'hB194BAC80A08F53B, 64'h366D008E584A5DE4, 64'h8504FA9D1BB6C7AC, 64'h252E72C202FDCE0D,
        64'h5BE3D61217B96181, 64'hFE6786AD716B890B, 64'h5CB0C0FF33C356B8, 64'h35C405AED8E07F99,
        64'hE12BDC1AE28257EC, 64'h703FCCF095EE8DF1, 64'hC1AB76389FE678CA, 64'hF7C6F860D5BB9C4F,
        64'hF33C657B637C306A, 64'hDD4EA7799EB23D31, 64'h3E98B56E27D3BCCF, 64'h591E181F4C5AB793,
        64'hE9DEE72C8F0C0FA6, 64'h2DDB49F46F739647, 64'h06075316ED247A37, 64'h39CBA38303A98BF6,
        64'h92BD9B1CE5D14101, 64'h5445FBC95E4D0EF2, 64'h682080AA227D642F, 64'h2687F93490405511
    };

    logic          clk = 1'b0;
    logic          rstn_i, in_valid_i, out_ready_i;
    logic [1535:0] state_i, state_o;
    logic          in_ready_o, out_valid_o, busy_o;
    logic [4:0]    round_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bash_f_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .state_o     (state_o),
        .busy_o      (busy_o),
        .round_o     (round_o)
    );

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} << n;
        return d[127:64];
    endfunction

    // Behavioural Bash-f: column parameters and P derived arithmetically
    function automatic logic [1535:0] ref_bash_f(input logic [1535:0] x);
        logic [63:0] s [24];
        logic [63:0] t [24];
        logic [63:0] c, w0, w1, w2, t0, t1, t2;
        logic [1535:0] y;
        int m1, n1, m2, n2;
        c = C1;
        for (int j = 0; j < 24; j++) s[j] = x[64*j +: 64];
        for (int r = 0; r < ROUNDS; r++) begin
            m1 = 8; n1 = 53; m2 = 14; n2 = 1;
            for (int i = 0; i < 8; i++) begin
                w0 = s[i]; w1 = s[i+8]; w2 = s[i+16];
                t2 = rl(w0, m1);
                w0 = w0 ^ w1 ^ w2;
                t1 = w1 ^ rl(w0, n1);
                w1 = t1 ^ t2;
                w2 = w2 ^ rl(w2, m2) ^ (t1 << n2);
                t1 = w0 | w2;
                t2 = w0 & w1;
                t0 = ~w2 | w1;
                s[i] = w0 ^ t0; s[i+8] = w1 ^ t1; s[i+16] = w2 ^ t2;
                m1 = (m1 * 7) % 64; n1 = (n1 * 7) % 64; m2 = (m2 * 7) % 64; n2 = (n2 * 7) % 64;
            end
            for (int j = 0; j < 8; j++) begin
                t[j]      = s[8 + ((j + 2 * (j % 2) + 7) % 8)];
                t[8 + j]  = s[16 + (j ^ 1)];
                t[16 + j] = s[(5 * j + 6) % 8];
            end
            t[23] = t[23] ^ c;
            s = t;
            c = (c >> 1) ^ (c[0] ? POLY : 64'd0);
        end
        for (int j = 0; j < 24; j++) y[64*j +: 64] = s[j];
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [1535:0] vec, input int hold,
                           input bit noisy, output logic [1535:0] result);
        int cyc;
        int low;
        out_ready_i = (hold == 0);
        state_i     = vec;
        in_valid_i  = 1'b1;
        chk({tag, "_ready_at_accept"}, in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        cyc = 0;
        low = 0;
        while (!out_valid_o && cyc < 4 * LAT) begin
            if (!in_ready_o) low++;
            chk({tag, "_round_o"}, round_o, (cyc < LAT - 1) ? cyc * STEP : 0);
            chk({tag, "_busy"}, busy_o, 1'b1);
            if (cyc == 0) chk({tag, "_const_r0"}, dut.c_q, C1);
`ifndef BASH_F_UNROLL2_EN
            if (cyc == 1) chk({tag, "_const_r1"}, dut.c_q, C2);
`endif
            if (noisy) begin
                in_valid_i = 1'($urandom_range(0, 1));
                for (int k = 0; k < 48; k++) state_i[32*k +: 32] = $urandom();
            end
            tick();
            cyc++;
        end
        in_valid_i = 1'b0;
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_valid"}, out_valid_o, 1'b1);
        result = state_o;
        for (int h = 0; h < hold; h++) begin
            if (!in_ready_o) low++;
            chk({tag, "_hold_state"}, state_o, result);
            chk({tag, "_hold_valid"}, out_valid_o, 1'b1);
            tick();
        end
        out_ready_i = 1'b1;
        if (!in_ready_o) low++;
        tick();
        chk({tag, "_ready_back"}, in_ready_o, 1'b1);
        chk({tag, "_valid_drop"}, out_valid_o, 1'b0);
        chk({tag, "_ready_low_cycles"}, low, LAT + 1 + hold);
    endtask

    initial begin
        logic [1535:0] std_vec, std_exp, zero_exp, r_a, r_b;
        int n;
        bit seen;
        for (int j = 0; j < 24; j++) std_vec[64*j +: 64] = STD_W[j];
        std_exp  = ref_bash_f(std_vec);
        zero_exp = ref_bash_f('0);

        rstn_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; state_i = '0;
        repeat (3) tick();
        chk("reset_in_ready", in_ready_o, 1'b1);
        chk("reset_out_valid", out_valid_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_round", round_o, 5'd0);
        chk("reset_state_o", state_o, '0);
        chk("reset_const", dut.c_q, C1);
        rstn_i = 1'b1;

        run_vec("std", std_vec, 0, 1'b0, r_a);
        chk("std_result", r_a, std_exp);

        run_vec("zero_a", '0, 0, 1'b0, r_a);
        run_vec("zero_b", '0, 0, 1'b0, r_b);
        chk("zero_ref", r_a, zero_exp);
        chk("zero_repeat", r_b, r_a);

        run_vec("bp", std_vec, 10, 1'b0, r_a);
        chk("bp_result", r_a, std_exp);

        run_vec("noise", std_vec, 0, 1'b1, r_a);
        chk("noise_result", r_a, std_exp);

        // Reset while round 10 is in flight
        state_i = std_vec; in_valid_i = 1'b1; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (round_o != 5'd10 && n < 4 * LAT) begin
            tick();
            n++;
        end
        chk("rst_reached_r10", round_o, 5'd10);
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_round", round_o, 5'd0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_state_o", state_o, '0);
        chk("rst_const", dut.c_q, C1);
        seen = 1'b0;
        repeat (LAT + 5) begin
            if (out_valid_o) seen = 1'b1;
            tick();
        end
        chk("rst_no_valid_pulse", seen, 1'b0);

        run_vec("post_rst", std_vec, 0, 1'b0, r_a);
        chk("post_rst_result", r_a, std_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
